// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared definitions for the neural-datapath run controller:
//               sequencer state encodings, the fixed-point width and a small
//               helper used to size phase timers.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

  // Fixed-point word width shared with the datapath (the `n` of the
  // fixed-point header). Also the default batch-counter width.
  localparam int FP_N = 16;

  // Sequencer states; the numeric values are visible on the phase output.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FWD   = 3'd2,
    ST_STORE = 3'd3,
    ST_BP    = 3'd4,
    ST_UPD   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Largest of three latencies; sizes the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage : nn_pkg
`default_nettype wire

// File: rtl/nn_sequencer_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Loadable down-counter with terminal-count flag. Loaded with
//               (duration - 1) on entry to a timed phase; tc_o is high in
//               the last cycle of that phase.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule : phase_timer
`default_nettype wire

// File: rtl/nn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nn_sequencer
// Description : Run controller for the fixed-point neural datapath. Per
//               sample it sequences fetch, per-layer forward enables, output
//               write-back and backprop accumulation, then issues one weight
//               update per batch, for a latched number of epochs.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_sequencer
  import nn_pkg::*;
#(
  parameter int A       = 32,
  parameter int N       = FP_N,
  parameter int LTOT    = 3,
  parameter int MEM_LAT = 2,
  parameter int L_LAT   = 4,
  parameter int BP_LAT  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [N-1:0]    batch,
  input  logic [15:0]     epochs,
  output logic            busy,
  output logic            done,
  output logic [2:0]      phase,
  output logic [A-1:0]    x_addr,
  output logic [A-1:0]    t_addr,
  output logic [A-1:0]    y_addr,
  output logic [LTOT-2:0] layer_en,
  output logic            y_we,
  output logic            bp_acc,
  output logic            w_upd,
  output logic [N-1:0]    sample_idx,
  output logic [15:0]     epoch_idx
);

  localparam int NL     = LTOT - 1;
  localparam int LW     = (NL > 1) ? $clog2(NL) : 1;
  localparam int MAXLAT = max3(MEM_LAT, L_LAT, BP_LAT);
  localparam int TW     = $clog2(MAXLAT + 1);

  state_e          state_q, state_d;
  logic [LW-1:0]   layer_q, layer_d;
  logic [N-1:0]    sample_q, sample_d, batch_q, batch_d;
  logic [15:0]     epoch_q, epoch_d, epochs_q, epochs_d;
  logic            tmr_load, tmr_tc;
  logic [TW-1:0]   tmr_val;
  logic [NL-1:0]   layer_oh_d;

  logic            busy_q, done_q, y_we_q, bp_acc_q, w_upd_q;
  logic [NL-1:0]   layer_en_q;
  logic [A-1:0]    x_addr_q, t_addr_q, y_addr_q;

  phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // Next-state, counter and timer-load decisions; abort outranks everything.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    sample_d = sample_q;
    epoch_d  = epoch_q;
    batch_d  = batch_q;
    epochs_d = epochs_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      layer_d  = '0;
      sample_d = '0;
      epoch_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            batch_d  = batch;
            epochs_d = epochs;
            sample_d = '0;
            epoch_d  = '0;
            layer_d  = '0;
            if ((batch == '0) || (epochs == '0)) begin
              state_d = ST_DONE;
            end else begin
              state_d  = ST_LOAD;
              tmr_load = 1'b1;
              tmr_val  = TW'(MEM_LAT - 1);
            end
          end
        end
        ST_LOAD: begin
          if (tmr_tc) begin
            state_d  = ST_FWD;
            layer_d  = '0;
            tmr_load = 1'b1;
            tmr_val  = TW'(L_LAT - 1);
          end
        end
        ST_FWD: begin
          if (tmr_tc) begin
            if (layer_q == LW'(NL - 1)) begin
              state_d = ST_STORE;
            end else begin
              layer_d  = layer_q + LW'(1);
              tmr_load = 1'b1;
              tmr_val  = TW'(L_LAT - 1);
            end
          end
        end
        ST_STORE: begin
          state_d  = ST_BP;
          tmr_load = 1'b1;
          tmr_val  = TW'(BP_LAT - 1);
        end
        ST_BP: begin
          if (tmr_tc) begin
            if (sample_q == batch_q - N'(1)) begin
              state_d = ST_UPD;
            end else begin
              sample_d = sample_q + N'(1);
              state_d  = ST_LOAD;
              tmr_load = 1'b1;
              tmr_val  = TW'(MEM_LAT - 1);
            end
          end
        end
        ST_UPD: begin
          if (epoch_q == epochs_q - 16'd1) begin
            state_d = ST_DONE;
          end else begin
            epoch_d  = epoch_q + 16'd1;
            sample_d = '0;
            state_d  = ST_LOAD;
            tmr_load = 1'b1;
            tmr_val  = TW'(MEM_LAT - 1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // One-hot decode of the next layer index, registered below with the state.
  always_comb begin
    layer_oh_d = '0;
    for (int k = 0; k < NL; k++) begin
      layer_oh_d[k] = (layer_d == LW'(k));
    end
  end

  // State, counters and outputs registered together so strobes align with phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      layer_q    <= '0;
      sample_q   <= '0;
      epoch_q    <= '0;
      batch_q    <= '0;
      epochs_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      y_we_q     <= 1'b0;
      bp_acc_q   <= 1'b0;
      w_upd_q    <= 1'b0;
      layer_en_q <= '0;
      x_addr_q   <= '0;
      t_addr_q   <= '0;
      y_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      sample_q   <= sample_d;
      epoch_q    <= epoch_d;
      batch_q    <= batch_d;
      epochs_q   <= epochs_d;
      busy_q     <= (state_d inside {ST_LOAD, ST_FWD, ST_STORE, ST_BP, ST_UPD});
      done_q     <= (state_d == ST_DONE);
      y_we_q     <= (state_d == ST_STORE);
      bp_acc_q   <= (state_d == ST_BP);
      w_upd_q    <= (state_d == ST_UPD);
      layer_en_q <= (state_d == ST_FWD) ? layer_oh_d : '0;
      // Addresses only move in the phases that consume them.
      if (state_d == ST_LOAD) begin
        x_addr_q <= A'(sample_d);
        t_addr_q <= A'(sample_d);
      end
      if (state_d == ST_STORE) begin
        y_addr_q <= A'(sample_d);
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign phase      = state_q;
  assign x_addr     = x_addr_q;
  assign t_addr     = t_addr_q;
  assign y_addr     = y_addr_q;
  assign layer_en   = layer_en_q;
  assign y_we       = y_we_q;
  assign bp_acc     = bp_acc_q;
  assign w_upd      = w_upd_q;
  assign sample_idx = sample_q;
  assign epoch_idx  = epoch_q;

endmodule : nn_sequencer
`default_nettype wire

// File: tb/tb_nn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_sequencer
// Description : Scoreboard bench for nn_sequencer. Each run request pushes
//               the cycle-by-cycle expected trace derived from the phase
//               durations; a monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_sequencer;

  localparam int A       = 32;
  localparam int N       = 4;
  localparam int LTOT    = 3;
  localparam int MEM_LAT = 2;
  localparam int L_LAT   = 4;
  localparam int BP_LAT  = 3;
  localparam int NL      = LTOT - 1;

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [N-1:0]    batch;
  logic [15:0]     epochs;
  logic            busy, done, y_we, bp_acc, w_upd;
  logic [2:0]      phase;
  logic [A-1:0]    x_addr, t_addr, y_addr;
  logic [NL-1:0]   layer_en;
  logic [N-1:0]    sample_idx;
  logic [15:0]     epoch_idx;

  nn_sequencer #(
    .A(A), .N(N), .LTOT(LTOT), .MEM_LAT(MEM_LAT), .L_LAT(L_LAT), .BP_LAT(BP_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .batch(batch),
    .epochs(epochs), .busy(busy), .done(done), .phase(phase),
    .x_addr(x_addr), .t_addr(t_addr), .y_addr(y_addr), .layer_en(layer_en),
    .y_we(y_we), .bp_acc(bp_acc), .w_upd(w_upd), .sample_idx(sample_idx),
    .epoch_idx(epoch_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    int            ph;
    logic [NL-1:0] len;
    int            smp;
    int            ep;
    bit            cnt_chk;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input int c, input int ph, input logic [NL-1:0] len,
                      input int smp, input int ep, input bit cc);
    exp_t r;
    r.cyc = c; r.ph = ph; r.len = len; r.smp = smp; r.ep = ep; r.cnt_chk = cc;
    q.push_back(r);
  endtask

  // Expected trace of a whole run starting at cycle base: nested loops over
  // epochs, samples and phase durations.
  task automatic model_run(input int base, input int b, input int e, output int last);
    int t;
    logic [NL-1:0] oh;
    t = base;
    if (b == 0 || e == 0) begin
      push(t, 6, '0, 0, 0, 1'b0);
      last = t;
      return;
    end
    for (int ep = 0; ep < e; ep++) begin
      for (int s = 0; s < b; s++) begin
        for (int i = 0; i < MEM_LAT; i++) begin push(t, 1, '0, s, ep, 1'b1); t++; end
        for (int k = 0; k < NL; k++) begin
          oh = '0;
          oh[k] = 1'b1;
          for (int i = 0; i < L_LAT; i++) begin push(t, 2, oh, s, ep, 1'b1); t++; end
        end
        push(t, 3, '0, s, ep, 1'b1); t++;
        for (int i = 0; i < BP_LAT; i++) begin push(t, 4, '0, s, ep, 1'b1); t++; end
      end
      push(t, 5, '0, b - 1, ep, 1'b1); t++;
    end
    push(t, 6, '0, 0, 0, 1'b0);
    last = t;
  endtask

  // Drop expected entries at or after cycle c (run cut short).
  task automatic trim(input int c);
    while (q.size() > 0 && q[q.size()-1].cyc >= c) void'(q.pop_back());
  endtask

  // Monitor: compare against the expected trace, or against idle outputs.
  exp_t mr;
  bit   mok;
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      mr  = q.pop_front();
      mok = (phase == 3'(mr.ph)) && (layer_en == mr.len) &&
            (y_we == (mr.ph == 3)) && (bp_acc == (mr.ph == 4)) &&
            (w_upd == (mr.ph == 5)) && (done == (mr.ph == 6)) &&
            (busy == (mr.ph >= 1 && mr.ph <= 5));
      if (mr.cnt_chk)
        mok = mok && (int'(sample_idx) == mr.smp) && (int'(epoch_idx) == mr.ep);
      if (mr.ph == 1)
        mok = mok && (x_addr == A'(mr.smp)) && (t_addr == A'(mr.smp));
      if (mr.ph == 3)
        mok = mok && (y_addr == A'(mr.smp));
      checks++;
      if (!mok) begin
        errors++;
        $display("FAIL trace cyc=%0d got ph=%0d len=%b we=%b bp=%b wu=%b dn=%b bsy=%b smp=%0d ep=%0d xa=%0d ya=%0d, expected ph=%0d len=%b smp=%0d ep=%0d",
                 cyc, phase, layer_en, y_we, bp_acc, w_upd, done, busy, sample_idx,
                 epoch_idx, x_addr, y_addr, mr.ph, mr.len, mr.smp, mr.ep);
      end
    end else begin
      checks++;
      if (busy || done || phase != 3'd0 || layer_en != '0 || y_we || bp_acc || w_upd) begin
        errors++;
        $display("FAIL idle cyc=%0d got ph=%0d len=%b we=%b bp=%b wu=%b dn=%b bsy=%b, expected all zero",
                 cyc, phase, layer_en, y_we, bp_acc, w_upd, done, busy);
      end
    end
  end

  task automatic check_reset_vals(input string name);
    checks++;
    if (busy || done || phase != 0 || x_addr != 0 || t_addr != 0 || y_addr != 0 ||
        layer_en != 0 || y_we || bp_acc || w_upd || sample_idx != 0 || epoch_idx != 0) begin
      errors++;
      $display("FAIL %s got ph=%0d bsy=%b dn=%b xa=%0d ta=%0d ya=%0d len=%b smp=%0d ep=%0d, expected all zero",
               name, phase, busy, done, x_addr, t_addr, y_addr, layer_en, sample_idx, epoch_idx);
    end
  endtask

  // mode 0: normal, 1: abort at cycle base-1+off, 2: rst+start+abort there.
  task automatic run(input int b, input int e, input int mode, input int off, input bit junk);
    int base, last;
    @(negedge clk);
    base   = cyc + 1;
    start  = 1'b1;
    batch  = N'(b);
    epochs = 16'(e);
    model_run(base, b, e, last);
    @(negedge clk);
    start = 1'b0;
    while (cyc <= last) begin
      if (mode != 0 && cyc == base - 1 + off) begin
        if (mode == 1) begin
          abort = 1'b1;
        end else begin
          rst = 1'b1; start = 1'b1; abort = 1'b1;
        end
        trim(cyc + 1);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        if (mode == 2) begin
          check_reset_vals("mid_rst");
        end else begin
          checks++;
          if (sample_idx != 0 || epoch_idx != 0 || phase != 0) begin
            errors++;
            $display("FAIL abort_clear got ph=%0d smp=%0d ep=%0d, expected 0 0 0",
                     phase, sample_idx, epoch_idx);
          end
        end
        break;
      end
      if (junk) begin
        start  = 1'($urandom_range(0, 1));
        batch  = N'($urandom);
        epochs = 16'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, e, m, off;
    rst = 1'b1; start = 1'b0; abort = 1'b0; batch = '0; epochs = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    // Abort together with start while idle: must stay idle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; batch = N'(2); epochs = 16'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);

    run(2, 1, 0, 0, 1'b0);
    run(3, 2, 0, 0, 1'b1);
    run(0, 5, 0, 0, 1'b0);
    run(4, 0, 0, 0, 1'b1);
    run(2, 1, 1, 8, 1'b0);
    run(3, 1, 0, 0, 1'b0);
    run(3, 2, 2, 20, 1'b1);
    run(15, 1, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      b   = $urandom_range(0, 5);
      e   = $urandom_range(0, 3);
      m   = $urandom_range(0, 2);
      off = (b == 0 || e == 0) ? 1 : $urandom_range(1, MEM_LAT + NL * L_LAT + 1 + BP_LAT);
      run(b, e, m, off, 1'($urandom_range(0, 1)));
    end

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d pending entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nn_sequencer
`default_nettype wire
